candy_mdu: RTL and testbench



---
 rtl/candy_mdu.sv | 187 ++++++++++++++++++
 tb/tb_candy_mdu.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/candy_mdu.sv
// candy_mdu: sequential multiply/divide unit, one bit per cycle (shift-add / restoring divide).
// Define CANDY_MDU_SIGNED_EN to enable two's-complement operation via signed_i.
module candy_mdu #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               op_i,
    input  logic               signed_i,
    input  logic               annul_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               div_zero_o,
    output logic               busy_o,
    output logic               stallreq_o
);

    typedef enum logic [2:0] {StIdle, StZero, StMul, StDiv, StEnd} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]   lo_q;
    logic               zero_q;
    logic [2*WIDTH-1:0] result_q;
    logic               ready_q;
    logic               div_zero_q;

    logic               launch;
    logic               abort;
    logic               op2_zero;
    logic               last_iter;
    logic [WIDTH-1:0]   mag1;
    logic [WIDTH-1:0]   mag2;
    logic [2*WIDTH-1:0] raw;
    logic [2*WIDTH-1:0] fixed;

    assign launch    = start_i & ~annul_i;
    assign abort     = annul_i | ~start_i;
    assign op2_zero  = (opdata2_i == '0);
    assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));
    // Product and {remainder, quotient} share the same register layout.
    assign raw       = {acc_q, lo_q};

`ifdef CANDY_MDU_SIGNED_EN
    logic sgn1, sgn2;
    logic op_q, neg_q, rneg_q;

    assign sgn1 = signed_i & opdata1_i[WIDTH-1];
    assign sgn2 = signed_i & opdata2_i[WIDTH-1];
    assign mag1 = sgn1 ? -opdata1_i : opdata1_i;
    assign mag2 = sgn2 ? -opdata2_i : opdata2_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q   <= 1'b0;
            neg_q  <= 1'b0;
            rneg_q <= 1'b0;
        end else if (state_q == StIdle && launch) begin
            op_q   <= op_i;
            // Divide-by-zero returns raw operands, so no fix-up.
            neg_q  <= (sgn1 ^ sgn2) & ~(op_i & op2_zero);
            rneg_q <= sgn1 & op_i & ~op2_zero;
        end
    end

    always_comb begin
        fixed = raw;
        if (op_q) begin
            if (neg_q)  fixed[WIDTH-1:0]       = -lo_q;
            if (rneg_q) fixed[2*WIDTH-1:WIDTH] = -acc_q;
        end else if (neg_q) begin
            fixed = -raw;
        end
    end
`else
    logic unused_signed;

    assign unused_signed = signed_i;
    assign mag1          = opdata1_i;
    assign mag2          = opdata2_i;
    assign fixed         = raw;
`endif

    // One iteration of each algorithm.
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic             no_borrow;
    logic [WIDTH-1:0] acc_step;
    logic [WIDTH-1:0] lo_step;

    always_comb begin
        sum       = {1'b0, acc_q} + {1'b0, (lo_q[0] ? a_q : {WIDTH{1'b0}})};
        shifted   = {acc_q, lo_q[WIDTH-1]};
        no_borrow = (shifted >= {1'b0, a_q});
        if (state_q == StMul) begin
            acc_step = sum[WIDTH:1];
            lo_step  = {sum[0], lo_q[WIDTH-1:1]};
        end else begin
            acc_step = no_borrow ? (shifted[WIDTH-1:0] - a_q) : shifted[WIDTH-1:0];
            lo_step  = {lo_q[WIDTH-2:0], no_borrow};
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (launch) begin
                    if (op_i && op2_zero) state_d = StZero;
                    else if (op_i)        state_d = StDiv;
                    else                  state_d = StMul;
                end
            end
            StZero: state_d = abort ? StIdle : StEnd;
            StMul, StDiv: begin
                if (abort)          state_d = StIdle;
                else if (last_iter) state_d = StEnd;
            end
            StEnd:   if (!start_i) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            a_q        <= '0;
            acc_q      <= '0;
            lo_q       <= '0;
            zero_q     <= 1'b0;
            result_q   <= '0;
            ready_q    <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_q == StEnd) & start_i;
            case (state_q)
                StIdle: begin
                    if (launch) begin
                        cnt_q  <= '0;
                        zero_q <= op_i & op2_zero;
                        if (op_i && op2_zero) begin
                            a_q   <= '0;
                            acc_q <= opdata1_i;
                            lo_q  <= '1;
                        end else if (op_i) begin
                            a_q   <= mag2;
                            acc_q <= '0;
                            lo_q  <= mag1;
                        end else begin
                            a_q   <= mag1;
                            acc_q <= '0;
                            lo_q  <= mag2;
                        end
                    end
                end
                StMul, StDiv: begin
                    acc_q <= acc_step;
                    lo_q  <= lo_step;
                    cnt_q <= cnt_q + 1'b1;
                end
                StEnd: begin
                    // Result is captured once, on the edge that raises ready.
                    if (start_i && !ready_q) begin
                        result_q   <= fixed;
                        div_zero_q <= zero_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign result_o   = result_q;
    assign ready_o    = ready_q;
    assign div_zero_o = div_zero_q;
    assign busy_o     = (state_q != StIdle);
    assign stallreq_o = start_i & ~ready_q & ~annul_i;

endmodule

// File: tb/tb_candy_mdu.sv
// Directed self-checking bench for candy_mdu (WIDTH = 24); expectations follow CANDY_MDU_SIGNED_EN.
`timescale 1ns/1ps
module tb_candy_mdu;
    localparam int W = 24;

`ifdef CANDY_MDU_SIGNED_EN
    localparam logic [2*W-1:0] ExpSdiv   = {24'hFFFFFE, 24'hFFFFF2};
    localparam logic [2*W-1:0] ExpSdiv2  = {24'hFFFFFF, 24'hFFFFFD};
    localparam logic [2*W-1:0] ExpMinDiv = {24'h000000, 24'h800000};
    localparam logic [2*W-1:0] ExpSmul   = 48'hFFFF_FFFF_FFF1;
    localparam logic [2*W-1:0] ExpSmul2  = 48'd42;
`else
    localparam logic [2*W-1:0] ExpSdiv   = {24'h000006, 24'h24923A};
    localparam logic [2*W-1:0] ExpSdiv2  = {24'h000001, 24'h7FFFFC};
    localparam logic [2*W-1:0] ExpMinDiv = {24'h800000, 24'h000000};
    localparam logic [2*W-1:0] ExpSmul   = 48'h0000_04FF_FFF1;
    localparam logic [2*W-1:0] ExpSmul2  = 48'hFFFF_F300_002A;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic           start_i, op_i, signed_i, annul_i;
    logic [W-1:0]   opdata1_i, opdata2_i;
    logic [2*W-1:0] result_o;
    logic           ready_o, div_zero_o, busy_o, stallreq_o;

    int checks = 0;
    int errors = 0;

    candy_mdu #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .op_i       (op_i),
        .signed_i   (signed_i),
        .annul_i    (annul_i),
        .opdata1_i  (opdata1_i),
        .opdata2_i  (opdata2_i),
        .result_o   (result_o),
        .ready_o    (ready_o),
        .div_zero_o (div_zero_o),
        .busy_o     (busy_o),
        .stallreq_o (stallreq_o)
    );

    always #5 clk = ~clk;

    // Raise start with operands, then count edges after edge 0 until ready (-1 on timeout).
    task automatic issue(input logic op, input logic sgn, input logic [W-1:0] a,
                         input logic [W-1:0] b, output int lat);
        op_i = op; signed_i = sgn; opdata1_i = a; opdata2_i = b; start_i = 1'b1;
        @(posedge clk); #1;
        lat = -1;
        for (int n = 1; n <= 64; n++) begin
            @(posedge clk); #1;
            if (ready_o) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic release_op();
        start_i = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        checks++; if (result_o !== '0) begin errors++; $display("FAIL reset_result: got %h want 0", result_o); end
        checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", ready_o); end
        checks++; if (div_zero_o !== 1'b0) begin errors++; $display("FAIL reset_div_zero: got %b want 0", div_zero_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        checks++; if (stallreq_o !== 1'b0) begin errors++; $display("FAIL reset_stallreq: got %b want 0", stallreq_o); end
    endtask

    task automatic test_udiv();
        int lat;
        issue(1'b1, 1'b0, 24'd100, 24'd7, lat);
        checks++; if (lat !== W + 1) begin errors++; $display("FAIL udiv_latency: got %0d want %0d", lat, W + 1); end
        checks++; if (result_o !== {24'd2, 24'd14}) begin errors++; $display("FAIL udiv_result: got %h want %h", result_o, {24'd2, 24'd14}); end
        checks++; if (div_zero_o !== 1'b0) begin errors++; $display("FAIL udiv_div_zero: got %b want 0", div_zero_o); end
        checks++; if (stallreq_o !== 1'b0) begin errors++; $display("FAIL udiv_stallreq: got %b want 0", stallreq_o); end
        release_op();
        checks++; if (ready_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL udiv_release: got ready=%b busy=%b want 0 0", ready_o, busy_o); end
    endtask

    task automatic test_div_zero();
        int lat;
        issue(1'b1, 1'b0, 24'h000123, 24'h0, lat);
        checks++; if (lat !== 2) begin errors++; $display("FAIL dz_latency: got %0d want 2", lat); end
        checks++; if (result_o !== {24'h000123, 24'hFFFFFF}) begin errors++; $display("FAIL dz_result: got %h want %h", result_o, {24'h000123, 24'hFFFFFF}); end
        checks++; if (div_zero_o !== 1'b1) begin errors++; $display("FAIL dz_flag: got %b want 1", div_zero_o); end
        release_op();
        issue(1'b1, 1'b1, 24'hFFFF9C, 24'h0, lat);
        checks++; if (result_o !== {24'hFFFF9C, 24'hFFFFFF}) begin errors++; $display("FAIL dz_signed_result: got %h want %h", result_o, {24'hFFFF9C, 24'hFFFFFF}); end
        checks++; if (div_zero_o !== 1'b1) begin errors++; $display("FAIL dz_signed_flag: got %b want 1", div_zero_o); end
        release_op();
    endtask

    task automatic test_sdiv();
        int lat;
        issue(1'b1, 1'b1, 24'hFFFF9C, 24'd7, lat);
        checks++; if (lat !== W + 1) begin errors++; $display("FAIL sdiv_latency: got %0d want %0d", lat, W + 1); end
        checks++; if (result_o !== ExpSdiv) begin errors++; $display("FAIL sdiv_result: got %h want %h", result_o, ExpSdiv); end
        checks++; if (div_zero_o !== 1'b0) begin errors++; $display("FAIL sdiv_div_zero: got %b want 0", div_zero_o); end
        release_op();
        issue(1'b1, 1'b1, 24'hFFFFF9, 24'd2, lat);
        checks++; if (result_o !== ExpSdiv2) begin errors++; $display("FAIL sdiv2_result: got %h want %h", result_o, ExpSdiv2); end
        release_op();
        issue(1'b1, 1'b1, 24'h800000, 24'hFFFFFF, lat);
        checks++; if (result_o !== ExpMinDiv) begin errors++; $display("FAIL min_div_result: got %h want %h", result_o, ExpMinDiv); end
        release_op();
    endtask

    task automatic test_mul();
        int lat;
        issue(1'b0, 1'b1, 24'hFFFFFD, 24'd5, lat);
        checks++; if (lat !== W + 1) begin errors++; $display("FAIL smul_latency: got %0d want %0d", lat, W + 1); end
        checks++; if (result_o !== ExpSmul) begin errors++; $display("FAIL smul_result: got %h want %h", result_o, ExpSmul); end
        release_op();
        issue(1'b0, 1'b1, 24'hFFFFF9, 24'hFFFFFA, lat);
        checks++; if (result_o !== ExpSmul2) begin errors++; $display("FAIL smul2_result: got %h want %h", result_o, ExpSmul2); end
        release_op();
        issue(1'b0, 1'b0, 24'hFFFFFF, 24'hFFFFFF, lat);
        checks++; if (result_o !== 48'hFFFF_FE00_0001) begin errors++; $display("FAIL umul_max_result: got %h want %h", result_o, 48'hFFFF_FE00_0001); end
        release_op();
    endtask

    task automatic test_hold();
        int lat;
        issue(1'b0, 1'b0, 24'hFFFFFF, 24'hFFFFFF, lat);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL hold_ready[%0d]: got %b want 1", i, ready_o); end
            checks++; if (result_o !== 48'hFFFF_FE00_0001) begin errors++; $display("FAIL hold_result[%0d]: got %h want %h", i, result_o, 48'hFFFF_FE00_0001); end
        end
        release_op();
    endtask

    task automatic test_annul();
        int lat;
        int seen;
        op_i = 1'b0; signed_i = 1'b0; opdata1_i = 24'd1234; opdata2_i = 24'd5678; start_i = 1'b1;
        @(posedge clk); #1;
        repeat (10) begin @(posedge clk); #1; end
        checks++; if (busy_o !== 1'b1 || stallreq_o !== 1'b1) begin errors++; $display("FAIL annul_busy_before: got busy=%b stall=%b want 1 1", busy_o, stallreq_o); end
        annul_i = 1'b1;
        #1;
        checks++; if (stallreq_o !== 1'b0) begin errors++; $display("FAIL annul_stallreq: got %b want 0", stallreq_o); end
        @(posedge clk); #1;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL annul_idle: got busy=%b want 0", busy_o); end
        annul_i = 1'b0; start_i = 1'b0;
        seen = 0;
        repeat (30) begin @(posedge clk); #1; if (ready_o) seen++; end
        checks++; if (seen !== 0) begin errors++; $display("FAIL annul_no_ready: got %0d ready cycles want 0", seen); end
        issue(1'b0, 1'b0, 24'd1234, 24'd5678, lat);
        checks++; if (lat !== W + 1) begin errors++; $display("FAIL annul_restart_latency: got %0d want %0d", lat, W + 1); end
        checks++; if (result_o !== 48'd7006652) begin errors++; $display("FAIL annul_restart_result: got %h want %h", result_o, 48'd7006652); end
        release_op();
        // Dropping start mid-divide also aborts.
        op_i = 1'b1; opdata1_i = 24'd1000; opdata2_i = 24'd3; start_i = 1'b1;
        @(posedge clk); #1;
        repeat (5) begin @(posedge clk); #1; end
        start_i = 1'b0;
        @(posedge clk); #1;
        checks++; if (busy_o !== 1'b0 || ready_o !== 1'b0) begin errors++; $display("FAIL drop_start_abort: got busy=%b ready=%b want 0 0", busy_o, ready_o); end
        checks++; if (result_o !== 48'd7006652) begin errors++; $display("FAIL drop_start_result_held: got %h want %h", result_o, 48'd7006652); end
    endtask

    task automatic test_async_reset();
        int lat;
        op_i = 1'b1; signed_i = 1'b0; opdata1_i = 24'd100; opdata2_i = 24'd7; start_i = 1'b1;
        @(posedge clk); #1;
        repeat (8) begin @(posedge clk); #1; end
        #2;
        rst = 1'b0;
        #1;
        checks++; if (result_o !== '0) begin errors++; $display("FAIL areset_result: got %h want 0", result_o); end
        checks++; if (ready_o !== 1'b0 || div_zero_o !== 1'b0) begin errors++; $display("FAIL areset_flags: got ready=%b dz=%b want 0 0", ready_o, div_zero_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL areset_busy: got %b want 0", busy_o); end
        start_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        issue(1'b1, 1'b0, 24'd100, 24'd7, lat);
        checks++; if (lat !== W + 1 || result_o !== {24'd2, 24'd14}) begin errors++; $display("FAIL areset_recover: got lat=%0d result=%h want %0d %h", lat, result_o, W + 1, {24'd2, 24'd14}); end
        release_op();
    endtask

    task automatic test_back_to_back();
        int lat;
        issue(1'b0, 1'b0, 24'd3, 24'd5, lat);
        checks++; if (result_o !== 48'd15) begin errors++; $display("FAIL b2b_first: got %h want %h", result_o, 48'd15); end
        release_op();
        issue(1'b1, 1'b0, 24'd1000, 24'd10, lat);
        checks++; if (lat !== W + 1) begin errors++; $display("FAIL b2b_second_latency: got %0d want %0d", lat, W + 1); end
        checks++; if (result_o !== {24'd0, 24'd100}) begin errors++; $display("FAIL b2b_second: got %h want %h", result_o, {24'd0, 24'd100}); end
        release_op();
    endtask

    initial begin
        rst = 1'b0; start_i = 1'b0; op_i = 1'b0; signed_i = 1'b0; annul_i = 1'b0;
        opdata1_i = '0; opdata2_i = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_udiv();
        test_div_zero();
        test_sdiv();
        test_mul();
        test_hold();
        test_annul();
        test_async_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
